// File: rtl/color4x_lock_sequencer.sv
// color4x_lock_sequencer
//
// Reset/lock controller for the color4x MMCM, running on the 12 MHz board
// clock. It pulses the MMCM reset for a guaranteed minimum width, waits for
// the asynchronous LOCKED signal, and requires lock to hold continuously for a
// settle window before releasing the downstream reset. A lock timeout causes a
// retry. A lock drop during settle or run causes a full re-sequence.
//
// Ports:
//   clk_in12mhz     in   12 MHz clock; every flop is on its rising edge
//   reset           in   asynchronous, active-high reset
//   locked          in   MMCM LOCKED; asynchronous to clk_in12mhz
//   mmcm_reset      out  MMCM reset, high only in S_RST
//   rst_out         out  downstream reset, low only in S_RUN
//   ready           out  high only in S_RUN
//   timeout_count   out  saturating count of lock timeouts
//   lock_lost_count out  saturating count of lock drops seen in SETTLE/RUN
module color4x_lock_sequencer #(
    parameter int RST_PULSE_CYCLES    = 16,
    parameter int LOCK_TIMEOUT_CYCLES = 12000,
    parameter int SETTLE_CYCLES       = 256,
    parameter int CNT_W               = 8
) (
    input  logic             clk_in12mhz,
    input  logic             reset,
    input  logic             locked,
    output logic             mmcm_reset,
    output logic             rst_out,
    output logic             ready,
    output logic [CNT_W-1:0] timeout_count,
    output logic [CNT_W-1:0] lock_lost_count
);

    // The shared cycle counter must hold the largest of the three terminal values.
    localparam int MAX_RT  = (RST_PULSE_CYCLES > LOCK_TIMEOUT_CYCLES) ?
                             RST_PULSE_CYCLES : LOCK_TIMEOUT_CYCLES;
    localparam int MAX_ALL = (MAX_RT > SETTLE_CYCLES) ? MAX_RT : SETTLE_CYCLES;
    localparam int CYC_W   = $clog2(MAX_ALL) + 1;

    localparam logic [CYC_W-1:0] RST_LAST     = CYC_W'(RST_PULSE_CYCLES - 1);
    localparam logic [CYC_W-1:0] TIMEOUT_LAST = CYC_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CYC_W-1:0] SETTLE_LAST  = CYC_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX      = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        S_RST    = 2'd0,
        S_WAIT   = 2'd1,
        S_SETTLE = 2'd2,
        S_RUN    = 2'd3
    } state_t;

    state_t             state_reg, state_next;
    logic [CYC_W-1:0]   cyc_reg, cyc_next;
    logic               locked_meta_reg, locked_s_reg;
    logic [CNT_W-1:0]   timeout_count_reg, timeout_count_next;
    logic [CNT_W-1:0]   lock_lost_count_reg, lock_lost_count_next;
    logic               mmcm_reset_reg, mmcm_reset_next;
    logic               rst_out_reg, rst_out_next;
    logic               ready_reg, ready_next;
    logic               timeout_hit, lock_lost_hit;

    always_comb begin
        state_next    = state_reg;
        timeout_hit   = 1'b0;
        lock_lost_hit = 1'b0;

        case (state_reg)
            S_RST: begin
                if (cyc_reg == RST_LAST) begin
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                // A lock seen in the timeout cycle still wins.
                if (locked_s_reg) begin
                    state_next = S_SETTLE;
                end else if (cyc_reg == TIMEOUT_LAST) begin
                    state_next  = S_RST;
                    timeout_hit = 1'b1;
                end
            end
            S_SETTLE: begin
                if (!locked_s_reg) begin
                    state_next    = S_RST;
                    lock_lost_hit = 1'b1;
                end else if (cyc_reg == SETTLE_LAST) begin
                    state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (!locked_s_reg) begin
                    state_next    = S_RST;
                    lock_lost_hit = 1'b1;
                end
            end
            default: begin
                state_next = S_RST;
            end
        endcase

        // Counter restarts on every transition; it is parked in RUN so it
        // cannot wrap during an arbitrarily long run.
        if (state_next != state_reg) begin
            cyc_next = '0;
        end else if (state_reg == S_RUN) begin
            cyc_next = cyc_reg;
        end else begin
            cyc_next = cyc_reg + 1'b1;
        end

        timeout_count_next = timeout_count_reg;
        if (timeout_hit && (timeout_count_reg != CNT_MAX)) begin
            timeout_count_next = timeout_count_reg + 1'b1;
        end

        lock_lost_count_next = lock_lost_count_reg;
        if (lock_lost_hit && (lock_lost_count_reg != CNT_MAX)) begin
            lock_lost_count_next = lock_lost_count_reg + 1'b1;
        end

        // Output flops are loaded from the next state so that after each edge
        // they match the state register exactly.
        mmcm_reset_next = (state_next == S_RST);
        rst_out_next    = (state_next != S_RUN);
        ready_next      = (state_next == S_RUN);
    end

    always_ff @(posedge clk_in12mhz or posedge reset) begin
        if (reset) begin
            state_reg           <= S_RST;
            cyc_reg             <= '0;
            locked_meta_reg     <= 1'b0;
            locked_s_reg        <= 1'b0;
            timeout_count_reg   <= '0;
            lock_lost_count_reg <= '0;
            mmcm_reset_reg      <= 1'b1;
            rst_out_reg         <= 1'b1;
            ready_reg           <= 1'b0;
        end else begin
            state_reg           <= state_next;
            cyc_reg             <= cyc_next;
            locked_meta_reg     <= locked;
            locked_s_reg        <= locked_meta_reg;
            timeout_count_reg   <= timeout_count_next;
            lock_lost_count_reg <= lock_lost_count_next;
            mmcm_reset_reg      <= mmcm_reset_next;
            rst_out_reg         <= rst_out_next;
            ready_reg           <= ready_next;
        end
    end

    assign mmcm_reset      = mmcm_reset_reg;
    assign rst_out         = rst_out_reg;
    assign ready           = ready_reg;
    assign timeout_count   = timeout_count_reg;
    assign lock_lost_count = lock_lost_count_reg;

endmodule

// File: tb/tb_color4x_lock_sequencer.sv
// Bench for color4x_lock_sequencer: a default-parameter instance and a small
// instance (short timers, 2-bit counters) share clock, reset and locked.
// A spec-level reference model follows both instances every cycle, and
// table-driven vectors plus hand-written sequences check the edge timings.
module tb_color4x_lock_sequencer;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic locked = 1'b0;
    always #5 clk = ~clk;

    logic       mr0, ro0, rd0;
    logic [7:0] tc0, lc0;
    logic       mr1, ro1, rd1;
    logic [1:0] tc1, lc1;

    color4x_lock_sequencer dut0 (
        .clk_in12mhz(clk), .reset(reset), .locked(locked),
        .mmcm_reset(mr0), .rst_out(ro0), .ready(rd0),
        .timeout_count(tc0), .lock_lost_count(lc0)
    );

    color4x_lock_sequencer #(
        .RST_PULSE_CYCLES(4), .LOCK_TIMEOUT_CYCLES(8),
        .SETTLE_CYCLES(16), .CNT_W(2)
    ) dut1 (
        .clk_in12mhz(clk), .reset(reset), .locked(locked),
        .mmcm_reset(mr1), .rst_out(ro1), .ready(rd1),
        .timeout_count(tc1), .lock_lost_count(lc1)
    );

    int pass_cnt = 0;
    int total_cnt = 0;

    task automatic chk(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // ---------------- reference model ----------------
    // Phase: 0 reset pulse, 1 waiting for lock, 2 settling, 3 running.
    // elapsed counts cycles spent in the current phase.
    int P_RST[2] = '{16, 4};
    int P_TO[2]  = '{12000, 8};
    int P_SET[2] = '{256, 16};
    int P_MAX[2] = '{255, 3};
    int m_ph[2] = '{0, 0};
    int m_el[2] = '{0, 0};
    int m_tc[2] = '{0, 0};
    int m_lc[2] = '{0, 0};
    bit lk_d1 = 1'b0;   // locked one edge ago
    bit lk_d2 = 1'b0;   // locked two edges ago: what the sequencer acts on
    bit mdl_en = 1'b0;

    always @(posedge clk or posedge reset) begin
        int np;
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                m_ph[i] <= 0; m_el[i] <= 0; m_tc[i] <= 0; m_lc[i] <= 0;
            end
            lk_d1 <= 1'b0;
            lk_d2 <= 1'b0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                np = m_ph[i];
                if (m_ph[i] == 0) begin
                    if (m_el[i] == P_RST[i] - 1) np = 1;
                end else if (m_ph[i] == 1) begin
                    if (lk_d2) np = 2;
                    else if (m_el[i] == P_TO[i] - 1) begin
                        np = 0;
                        m_tc[i] <= (m_tc[i] < P_MAX[i]) ? m_tc[i] + 1 : m_tc[i];
                    end
                end else begin
                    if (!lk_d2) begin
                        np = 0;
                        m_lc[i] <= (m_lc[i] < P_MAX[i]) ? m_lc[i] + 1 : m_lc[i];
                    end else if (m_ph[i] == 2 && m_el[i] == P_SET[i] - 1) begin
                        np = 3;
                    end
                end
                m_ph[i] <= np;
                m_el[i] <= (np != m_ph[i]) ? 0 : m_el[i] + 1;
            end
            lk_d2 <= lk_d1;
            lk_d1 <= locked;
        end
    end

    function automatic int pack(bit m, bit r, bit y, int t, int l);
        return (int'(m) << 18) | (int'(r) << 17) | (int'(y) << 16) | (t << 8) | l;
    endfunction

    always @(negedge clk) begin
        if (mdl_en) begin
            chk("model_big", pack(mr0, ro0, rd0, int'(tc0), int'(lc0)),
                pack(m_ph[0] == 0, m_ph[0] != 3, m_ph[0] == 3, m_tc[0], m_lc[0]));
            chk("model_small", pack(mr1, ro1, rd1, int'(tc1), int'(lc1)),
                pack(m_ph[1] == 0, m_ph[1] != 3, m_ph[1] == 3, m_tc[1], m_lc[1]));
        end
    end

    // ---------------- helpers ----------------
    task automatic check_reset_vals(input string tag);
        chk({tag, "_mmcm_reset"}, int'(mr0), 1);
        chk({tag, "_rst_out"}, int'(ro0), 1);
        chk({tag, "_ready"}, int'(rd0), 0);
        chk({tag, "_counters"}, int'(tc0) + int'(lc0), 0);
    endtask

    // Holds reset for one cycle and releases it 1 time unit after an edge;
    // the next rising edge is edge 1 for the caller's edge count.
    task automatic do_reset(input bit lk);
        @(posedge clk); #1;
        reset = 1'b1;
        locked = 1'b0;
        #1 check_reset_vals("rst_hold");
        @(posedge clk); #1;
        locked = lk;
        reset = 1'b0;
    endtask

    typedef struct {
        int lock_edge;      // locked driven high just after this edge (0 = at release)
        int exp_mmcm_fall;  // edge after which mmcm_reset is first low
        int exp_rst_fall;   // edge after which rst_out is first low
    } vec_t;

    vec_t tbl[6];

    initial begin
        int n, mf, rf, mr_rise, mr_fall2;
        bit ro_dropped;

        tbl[0] = '{0,   16, 273};   // locked high through the reset pulse
        tbl[1] = '{10,  16, 273};
        tbl[2] = '{14,  16, 273};   // visible exactly as WAIT begins
        tbl[3] = '{15,  16, 274};   // one cycle too late for that
        tbl[4] = '{16,  16, 275};
        tbl[5] = '{116, 16, 375};   // 100 cycles after mmcm_reset falls

        do_reset(1'b0);
        mdl_en = 1'b1;

        // ---- table-driven lock timing ----
        foreach (tbl[k]) begin
            do_reset(tbl[k].lock_edge == 0);
            n = 0; mf = -1; rf = -1;
            while (n < 700 && rf < 0) begin
                @(posedge clk); #1;
                n++;
                if (n == tbl[k].lock_edge) locked = 1'b1;
                if (mf < 0 && !mr0) mf = n;
                if (rf < 0 && !ro0) rf = n;
            end
            chk($sformatf("vec%0d_mmcm_fall", k), mf, tbl[k].exp_mmcm_fall);
            chk($sformatf("vec%0d_rst_fall", k), rf, tbl[k].exp_rst_fall);
            chk($sformatf("vec%0d_ready", k), int'(rd0), 1);
            chk($sformatf("vec%0d_counters", k), int'(tc0) + int'(lc0), 0);
            $display("vec%0d lock_edge=%0d mmcm_fall=%0d rst_fall=%0d", k,
                     tbl[k].lock_edge, mf, rf);
        end

        // ---- timeout retry (big) and counter saturation (small) ----
        do_reset(1'b0);
        n = 0; mr_rise = -1; mr_fall2 = -1; rf = -1; ro_dropped = 1'b0;
        while (n < 12600 && rf < 0) begin
            @(posedge clk); #1;
            n++;
            if (n > 16 && mr_rise < 0 && mr0) mr_rise = n;
            if (mr_rise > 0 && mr_fall2 < 0 && !mr0) mr_fall2 = n;
            if (n < 12040 && !ro0) ro_dropped = 1'b1;
            if (n == 12016) chk("timeout_count_1", int'(tc0), 1);
            if (n == 12) chk("sat_count_1", int'(tc1), 1);
            if (n == 24) chk("sat_count_2", int'(tc1), 2);
            if (n == 36) chk("sat_count_3", int'(tc1), 3);
            if (n == 130) chk("sat_count_held", int'(tc1), 3);
            if (n == 12040) locked = 1'b1;
            if (n > 12040 && !ro0) rf = n;
        end
        chk("timeout_mmcm_rise", mr_rise, 12016);
        chk("timeout_mmcm_fall", mr_fall2, 12032);
        chk("timeout_rst_held", int'(ro_dropped), 0);
        chk("timeout_release", rf, 12299);
        chk("timeout_ready", int'(rd0), 1);
        $display("timeout: mmcm_rise=%0d refall=%0d release=%0d tc=%0d", mr_rise,
                 mr_fall2, rf, tc0);

        // ---- settle glitch, then lock loss in RUN ----
        do_reset(1'b1);
        n = 0; rf = -1; mf = -1; ro_dropped = 1'b0;
        while (n < 600) begin
            @(posedge clk); #1;
            n++;
            if (n == 67) locked = 1'b0;
            if (n == 70) locked = 1'b1;
            if (n == 400) locked = 1'b0;
            if (n == 401) locked = 1'b1;
            if (n < 343 && !ro0) ro_dropped = 1'b1;
            if (n == 72) chk("glitch_lost_1", int'(lc0), 1);
            if (rf < 0 && n > 300 && !ro0) rf = n;
            if (n == 402) chk("runloss_ready_before", int'(rd0), 1);
            if (n == 403) begin
                chk("runloss_ready", int'(rd0), 0);
                chk("runloss_rst_out", int'(ro0), 1);
                chk("runloss_lost_2", int'(lc0), 2);
            end
            if (n > 403 && mf < 0 && !mr0) mf = n;
        end
        chk("glitch_rst_held", int'(ro_dropped), 0);
        chk("glitch_release", rf, 343);
        chk("runloss_mmcm_fall", mf, 419);
        $display("glitch/runloss: release=%0d remmcm_fall=%0d lost=%0d", rf, mf, lc0);

        // ---- asynchronous reset while in SETTLE (sequencer still settling) ----
        #1 reset = 1'b1;
        #1 check_reset_vals("async_settle");
        reset = 1'b0;
        n = 0; rf = -1;
        while (n < 300) begin
            @(posedge clk); #1;
            n++;
            if (rf < 0 && !ro0) rf = n;
        end
        chk("async_restart_release", rf, 273);

        // ---- asynchronous reset while in RUN ----
        #1 reset = 1'b1;
        #1 check_reset_vals("async_run");
        #1 reset = 1'b0;
        n = 0; mf = -1;
        while (n < 20) begin
            @(posedge clk); #1;
            n++;
            if (mf < 0 && !mr0) mf = n;
        end
        chk("async_restart_mmcm_fall", mf, 16);
        $display("async reset: settle-restart release=%0d run-restart mmcm_fall=%0d", rf, mf);

        // ---- randomized locked / reset activity against the model ----
        do_reset(1'b0);
        for (int c = 0; c < 8000; c++) begin
            @(posedge clk); #1;
            if ($urandom_range(0, 299) == 0) begin
                reset = 1'b1;
                #2 reset = 1'b0;
            end
            if ($urandom_range(0, 39) == 0) locked = ~locked;
        end
        $display("random: done, small tc=%0d lc=%0d", tc1, lc1);

        mdl_en = 1'b0;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
